// File: rtl/at_field_parser.sv
// Byte-stream parser for "+HEART=<digits>\r" and "+T=<int>.<frac>" telemetry fields.
// Optional ERR_CNT_EN adds a saturating 8-bit parse-error counter output (err_cnt).
module at_field_parser #(
    parameter int         HR_DIGITS   = 3,
    parameter int         T_INT       = 2,
    parameter int         T_FRAC      = 2,
    parameter logic [7:0] PAD_CHAR    = 8'h3A,
    parameter logic [7:0] NONE_CHAR   = 8'h2F,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_done,
    output logic [8*HR_DIGITS-1:0] heart_ascii,
    output logic                   heart_none,
    output logic                   heart_vld,
    output logic [8*T_INT-1:0]     temp_int_ascii,
    output logic [8*T_FRAC-1:0]    temp_frac_ascii,
    output logic                   temp_vld,
    output logic                   parse_err,
`ifdef ERR_CNT_EN
    output logic [7:0]             err_cnt,
`endif
    output logic                   busy
);

    localparam int HC_W  = $clog2(HR_DIGITS + 1);
    localparam int T_MAX = (T_INT > T_FRAC) ? T_INT : T_FRAC;
    localparam int TC_W  = $clog2(T_MAX + 1);
    localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]   TMO_LAST    = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [HC_W-1:0] HR_FULL     = HC_W'(HR_DIGITS);
    localparam logic [TC_W-1:0] T_INT_LAST  = TC_W'(T_INT - 1);
    localparam logic [TC_W-1:0] T_FRAC_LAST = TC_W'(T_FRAC - 1);

    typedef enum logic [3:0] {
        IDLE, PLUS, KEY_H, EQ_H, HR_DIG, KEY_T_EQ, T_INT_S, T_DOT, T_FRAC_S
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             key_q, key_d;
    logic [HC_W-1:0]        hr_cnt_q, hr_cnt_d;
    logic [TC_W-1:0]        t_cnt_q, t_cnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [8*HR_DIGITS-1:0] hr_sh_q, hr_sh_d;
    logic [8*T_INT-1:0]     ti_sh_q, ti_sh_d;
    logic [8*T_FRAC-1:0]    tf_sh_q, tf_sh_d;
    logic [8*HR_DIGITS-1:0] heart_q, heart_d;
    logic                   none_q, none_d;
    logic [8*T_INT-1:0]     tint_q, tint_d;
    logic [8*T_FRAC-1:0]    tfrac_q, tfrac_d;
    logic                   hvld_q, hvld_d;
    logic                   tvld_q, tvld_d;
    logic                   perr_q, perr_d;
    logic                   tmo_expire;

    function automatic logic [7:0] key_char(input logic [1:0] idx);
        case (idx)
            2'd0:    key_char = 8'h45; // E
            2'd1:    key_char = 8'h41; // A
            2'd2:    key_char = 8'h52; // R
            default: key_char = 8'h54; // T
        endcase
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        is_digit = (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_expire = (TIMEOUT_CYC != 0) && (state_q != IDLE) && !rx_done && (tmo_q == TMO_LAST);

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        hr_cnt_d = hr_cnt_q;
        t_cnt_d  = t_cnt_q;
        hr_sh_d  = hr_sh_q;
        ti_sh_d  = ti_sh_q;
        tf_sh_d  = tf_sh_q;
        heart_d  = heart_q;
        none_d   = none_q;
        tint_d   = tint_q;
        tfrac_d  = tfrac_q;
        hvld_d   = 1'b0;
        tvld_d   = 1'b0;
        perr_d   = 1'b0;
        tmo_d    = '0;

        if (rx_done) begin
            if (state_q != IDLE && rx_byte == 8'h2B) begin
                perr_d  = 1'b1;
                state_d = PLUS;
            end else begin
                case (state_q)
                    IDLE: if (rx_byte == 8'h2B) state_d = PLUS;
                    PLUS: begin
                        key_d = '0;
                        if (rx_byte == 8'h48)      state_d = KEY_H;
                        else if (rx_byte == 8'h54) state_d = KEY_T_EQ;
                        else                       state_d = IDLE;
                    end
                    KEY_H: begin
                        if (rx_byte != key_char(key_q)) state_d = IDLE;
                        else if (key_q == 2'd3)         state_d = EQ_H;
                        else                            key_d = key_q + 2'd1;
                    end
                    EQ_H: begin
                        hr_cnt_d = '0;
                        if (rx_byte == 8'h3D) state_d = HR_DIG;
                        else begin
                            perr_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    HR_DIG: begin
                        if (rx_byte == 8'h4E && hr_cnt_q == '0) begin
                            heart_d = {HR_DIGITS{NONE_CHAR}};
                            none_d  = 1'b1;
                            hvld_d  = 1'b1;
                            state_d = IDLE;
                        end else if (is_digit(rx_byte)) begin
                            if (hr_cnt_q < HR_FULL) begin
                                hr_sh_d[8*(HR_DIGITS-1-int'(hr_cnt_q)) +: 8] = rx_byte;
                                hr_cnt_d = hr_cnt_q + 1'b1;
                            end
                        end else if (rx_byte == 8'h0D && hr_cnt_q != '0) begin
                            for (int i = 0; i < HR_DIGITS; i++)
                                heart_d[8*(HR_DIGITS-1-i) +: 8] = (i < int'(hr_cnt_q)) ?
                                    hr_sh_q[8*(HR_DIGITS-1-i) +: 8] : PAD_CHAR;
                            none_d  = 1'b0;
                            hvld_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            perr_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    KEY_T_EQ: begin
                        t_cnt_d = '0;
                        state_d = (rx_byte == 8'h3D) ? T_INT_S : IDLE;
                    end
                    T_INT_S: begin
                        if (is_digit(rx_byte)) begin
                            ti_sh_d[8*(T_INT-1-int'(t_cnt_q)) +: 8] = rx_byte;
                            if (t_cnt_q == T_INT_LAST) begin
                                t_cnt_d = '0;
                                state_d = T_DOT;
                            end else begin
                                t_cnt_d = t_cnt_q + 1'b1;
                            end
                        end else begin
                            perr_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    T_DOT: begin
                        t_cnt_d = '0;
                        if (rx_byte == 8'h2E) state_d = T_FRAC_S;
                        else begin
                            perr_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    T_FRAC_S: begin
                        if (is_digit(rx_byte)) begin
                            tf_sh_d[8*(T_FRAC-1-int'(t_cnt_q)) +: 8] = rx_byte;
                            if (t_cnt_q == T_FRAC_LAST) begin
                                // Last fraction digit goes straight to the output with the shadow.
                                tint_d  = ti_sh_q;
                                tfrac_d = tf_sh_d;
                                tvld_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                t_cnt_d = t_cnt_q + 1'b1;
                            end
                        end else begin
                            perr_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (tmo_expire) begin
            perr_d  = 1'b1;
            state_d = IDLE;
        end else if (state_q != IDLE) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            key_q    <= '0;
            hr_cnt_q <= '0;
            t_cnt_q  <= '0;
            tmo_q    <= '0;
            hr_sh_q  <= '0;
            ti_sh_q  <= '0;
            tf_sh_q  <= '0;
            heart_q  <= '0;
            none_q   <= 1'b0;
            tint_q   <= '0;
            tfrac_q  <= '0;
            hvld_q   <= 1'b0;
            tvld_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            hr_cnt_q <= hr_cnt_d;
            t_cnt_q  <= t_cnt_d;
            tmo_q    <= tmo_d;
            hr_sh_q  <= hr_sh_d;
            ti_sh_q  <= ti_sh_d;
            tf_sh_q  <= tf_sh_d;
            heart_q  <= heart_d;
            none_q   <= none_d;
            tint_q   <= tint_d;
            tfrac_q  <= tfrac_d;
            hvld_q   <= hvld_d;
            tvld_q   <= tvld_d;
            perr_q   <= perr_d;
        end
    end

`ifdef ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err_cnt_q <= '0;
        else if (perr_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;
`endif

    assign heart_ascii     = heart_q;
    assign heart_none      = none_q;
    assign heart_vld       = hvld_q;
    assign temp_int_ascii  = tint_q;
    assign temp_frac_ascii = tfrac_q;
    assign temp_vld        = tvld_q;
    assign parse_err       = perr_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_at_field_parser.sv
// Directed bench for at_field_parser: AT heart/temperature frames, errors, resync, timeout, reset.
module tb_at_field_parser;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_done = 1'b0;
    logic [23:0] heart_ascii;
    logic        heart_none, heart_vld;
    logic [15:0] temp_int_ascii, temp_frac_ascii;
    logic        temp_vld, parse_err, busy;
`ifdef ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int hv_cnt = 0, tv_cnt = 0, pe_cnt = 0;
    int hv0, tv0, pe0;

    at_field_parser #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_done(rx_done),
        .heart_ascii(heart_ascii), .heart_none(heart_none), .heart_vld(heart_vld),
        .temp_int_ascii(temp_int_ascii), .temp_frac_ascii(temp_frac_ascii),
        .temp_vld(temp_vld), .parse_err(parse_err),
`ifdef ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (heart_vld === 1'b1) hv_cnt <= hv_cnt + 1;
        if (temp_vld === 1'b1)  tv_cnt <= tv_cnt + 1;
        if (parse_err === 1'b1) pe_cnt <= pe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        hv0 = hv_cnt; tv0 = tv_cnt; pe0 = pe_cnt;
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_heart", heart_ascii, 32'h0);
        check("rst_none", heart_none, 32'h0);
        check("rst_tint", temp_int_ascii, 32'h0);
        check("rst_tfrac", temp_frac_ascii, 32'h0);
        check("rst_pulses", {heart_vld, temp_vld, parse_err}, 32'h0);
        check("rst_busy", busy, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Short heart-rate value padded on the right
        snap();
        send_str("+HEART=72");
        send_byte(8'h0D);
        check("hr72_vld_now", heart_vld, 32'h1);
        idle(2);
        check("hr72_ascii", heart_ascii, 32'h37323A);
        check("hr72_none", heart_none, 32'h0);
        check("hr72_vld_cnt", hv_cnt - hv0, 32'h1);
        check("hr72_err_cnt", pe_cnt - pe0, 32'h0);

        // No-reading frame; trailing CR is ignored in IDLE
        snap();
        send_str("+HEART=N");
        check("hrN_vld_now", heart_vld, 32'h1);
        send_byte(8'h0D);
        idle(2);
        check("hrN_ascii", heart_ascii, 32'h2F2F2F);
        check("hrN_none", heart_none, 32'h1);
        check("hrN_vld_cnt", hv_cnt - hv0, 32'h1);
        check("hrN_err_cnt", pe_cnt - pe0, 32'h0);

        // Temperature commit
        snap();
        send_str("+T=36.58");
        check("t3658_vld_now", temp_vld, 32'h1);
        idle(2);
        check("t3658_int", temp_int_ascii, 32'h3336);
        check("t3658_frac", temp_frac_ascii, 32'h3538);
        check("t3658_vld_cnt", tv_cnt - tv0, 32'h1);

        // Bad integer digit leaves temperature untouched
        snap();
        send_str("+T=3A");
        check("t3A_err_now", parse_err, 32'h1);
        check("t3A_busy", busy, 32'h0);
        send_str(".5");
        idle(2);
        check("t3A_int", temp_int_ascii, 32'h3336);
        check("t3A_frac", temp_frac_ascii, 32'h3538);
        check("t3A_err_cnt", pe_cnt - pe0, 32'h1);
        check("t3A_vld_cnt", tv_cnt - tv0, 32'h0);

        // Stall inside a frame: timeout fires exactly TMO cycles after the last byte
        snap();
        send_str("+HEA");
        idle(TMO - 1);
        check("tmo_early_err", parse_err, 32'h0);
        check("tmo_early_busy", busy, 32'h1);
        idle(1);
        check("tmo_err", parse_err, 32'h1);
        check("tmo_busy", busy, 32'h0);
        idle(3);
        check("tmo_err_cnt", pe_cnt - pe0, 32'h1);
        send_str("+HEART=101");
        send_byte(8'h0D);
        idle(2);
        check("hr101_ascii", heart_ascii, 32'h313031);
        check("hr101_none", heart_none, 32'h0);

        // Foreign AT traffic, then resync on a '+' mid-frame
        snap();
        send_str("+OK");
        send_byte(8'h0D);
        idle(2);
        check("ok_err_cnt", pe_cnt - pe0, 32'h0);
        send_str("+T=+");
        check("resync_err_now", parse_err, 32'h1);
        check("resync_busy", busy, 32'h1);
        send_str("T=12.34");
        check("t1234_vld_now", temp_vld, 32'h1);
        idle(2);
        check("t1234_int", temp_int_ascii, 32'h3132);
        check("t1234_frac", temp_frac_ascii, 32'h3334);
        check("resync_err_cnt", pe_cnt - pe0, 32'h1);

        // Extra digits are dropped; empty digit field is an error
        send_str("+HEART=1234");
        send_byte(8'h0D);
        idle(2);
        check("hr1234_ascii", heart_ascii, 32'h313233);
        snap();
        send_str("+HEART=");
        send_byte(8'h0D);
        check("hrE_err_now", parse_err, 32'h1);
        idle(2);
        check("hrE_ascii", heart_ascii, 32'h313233);
        check("hrE_vld_cnt", hv_cnt - hv0, 32'h0);

        // Asynchronous reset in the middle of a frame
        send_str("+HEART=9");
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_heart", heart_ascii, 32'h0);
        check("mid_rst_temp", {temp_int_ascii, temp_frac_ascii}, 32'h0);
        check("mid_rst_busy", busy, 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
